// File: rtl/double_counter_if.sv
// Count-control and count-result bundle for double_counter.
// The master side drives enable/select; the slave side returns both counts.
interface double_counter_if #(
    parameter int WIDTH = 64
);
    logic             En;
    logic             Slt;
    logic [WIDTH-1:0] Output0;
    logic [WIDTH-1:0] Output1;

    modport master (
        output En,
        output Slt,
        input  Output0,
        input  Output1
    );

    modport slave (
        input  En,
        input  Slt,
        output Output0,
        output Output1
    );
endinterface

// File: rtl/double_counter.sv
// Dual event counter: channel 0 counts every enabled cycle, channel 1 counts
// once per DIV enabled cycles via a prescaler that keeps its partial count.
module double_counter #(
    parameter int WIDTH = 64,
    parameter int DIV   = 4
) (
    input  logic              Clk,
    input  logic              Reset,
    double_counter_if.slave   bus
);
    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(DIV - 1);

    logic [WIDTH-1:0] cnt0;
    logic [WIDTH-1:0] cnt1;
    logic [PW-1:0]    pre;

    // Select steers the single enabled increment, so the channels never advance together.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            cnt0 <= '0;
            cnt1 <= '0;
            pre  <= '0;
        end else if (bus.En) begin
            if (!bus.Slt) begin
                cnt0 <= cnt0 + 1'b1;
            end else if (pre == LAST) begin
                pre  <= '0;
                cnt1 <= cnt1 + 1'b1;
            end else begin
                pre  <= pre + 1'b1;
            end
        end
    end

    assign bus.Output0 = cnt0;
    assign bus.Output1 = cnt1;
endmodule

// File: tb/tb_double_counter.sv
// Directed bench for double_counter: default 64-bit/DIV=4 instance plus a
// 4-bit/DIV=1 instance for wrap-around.
module tb_double_counter;
    logic Clk   = 1'b0;
    logic Reset = 1'b1;

    int tests = 0;
    int fails = 0;

    double_counter_if #(.WIDTH(64)) bus ();
    double_counter_if #(.WIDTH(4))  sbus ();

    double_counter #(.WIDTH(64), .DIV(4)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    double_counter #(.WIDTH(4), .DIV(1)) dut_small (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (sbus.slave)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.En  = 1'b0;
        bus.Slt = 1'b0;
        sbus.En  = 1'b0;
        sbus.Slt = 1'b0;

        #2;
        chk("reset_out0", bus.Output0, 64'd0);
        chk("reset_out1", bus.Output1, 64'd0);
        chk("reset_small_out0", {60'd0, sbus.Output0}, 64'd0);

        // Test 1: prescaled channel after reset (edges at 15, 25, 35, 45 ns)
        #8;
        Reset   = 1'b0;
        bus.En  = 1'b1;
        bus.Slt = 1'b1;
        step(3);
        chk("t1_out1_after3", bus.Output1, 64'd0);
        step(1);
        chk("t1_out1_after4", bus.Output1, 64'd1);
        chk("t1_time45", 64'($time), 64'd46);
        step(4);
        chk("t1_out1_after8", bus.Output1, 64'd2);
        chk("t1_out0_zero", bus.Output0, 64'd0);

        // Test 2: channel 0 only
        bus.Slt = 1'b0;
        step(10);
        chk("t2_out0", bus.Output0, 64'd10);
        chk("t2_out1_hold", bus.Output1, 64'd2);

        // Test 3: disabled, select toggling
        bus.En = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bus.Slt = ~bus.Slt;
            step(1);
        end
        chk("t3_out0_hold", bus.Output0, 64'd10);
        chk("t3_out1_hold", bus.Output1, 64'd2);

        // Test 4: partial prescale survives a channel-0 interlude
        bus.En  = 1'b1;
        bus.Slt = 1'b1;
        step(2);
        chk("t4_out1_partial", bus.Output1, 64'd2);
        bus.Slt = 1'b0;
        step(3);
        chk("t4_out0", bus.Output0, 64'd13);
        bus.Slt = 1'b1;
        step(1);
        chk("t4_out1_third", bus.Output1, 64'd2);
        step(1);
        chk("t4_out1_fourth", bus.Output1, 64'd3);

        // Test 6: asynchronous reset between edges with a partial prescale
        step(2);
        Reset = 1'b1;
        #1;
        chk("t6_async_out0", bus.Output0, 64'd0);
        chk("t6_async_out1", bus.Output1, 64'd0);
        #1;
        Reset = 1'b0;
        step(3);
        chk("t6_out1_after3", bus.Output1, 64'd0);
        step(1);
        chk("t6_out1_after4", bus.Output1, 64'd1);
        bus.Slt = 1'b0;
        step(1);
        chk("t6_out0_resume", bus.Output0, 64'd1);

        // Test 5: wrap-around on the 4-bit instance, main instance idle
        bus.En   = 1'b0;
        sbus.En  = 1'b1;
        sbus.Slt = 1'b0;
        step(15);
        chk("t5_small_allones", {60'd0, sbus.Output0}, 64'd15);
        step(1);
        chk("t5_small_wrap", {60'd0, sbus.Output0}, 64'd0);
        sbus.Slt = 1'b1;
        step(1);
        chk("t5_small_div1", {60'd0, sbus.Output1}, 64'd1);
        chk("t5_small_out0_hold", {60'd0, sbus.Output0}, 64'd0);
        step(15);
        chk("t5_small_out1_wrap", {60'd0, sbus.Output1}, 64'd0);
        chk("t5_main_hold", bus.Output0, 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
